// File: rtl/instr_ram_arbiter_pkg.sv
// Shared types and constants for the instruction RAM arbiter.
// Owner encoding, arbitration modes and the starvation counter width.
package instr_arb_pkg;
  typedef enum logic {OWNER_P0 = 1'b0, OWNER_P1 = 1'b1} arb_owner_e;

  localparam int ARB_MODE_PRIO = 0;
  localparam int ARB_MODE_RR   = 1;
  localparam int WAIT_CNT_W    = 8;
endpackage

// File: rtl/instr_ram_arbiter_if.sv
// One requester port of the instruction RAM arbiter: req/gnt/rvalid handshake.
// The master drives the request fields. The slave (the arbiter) returns the grant and the response.
interface instr_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                    req;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    gnt;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/instr_ram_arbiter_wait_counter.sv
// Saturating count of the consecutive cycles P1 has been denied.
// at_limit tells the arbiter to force a grant to P1.
module instr_arb_wait_counter
  import instr_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_inc,
  input  logic                  i_clr,
  input  logic [WAIT_CNT_W-1:0] i_limit,
  output logic                  o_at_limit
);
  logic [WAIT_CNT_W-1:0] r_cnt;

  // Clear has priority, and the count holds once it reaches the limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != i_limit)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt == i_limit);
endmodule

// File: rtl/instr_ram_arbiter.sv
// Shares one instruction RAM port between core fetch (P0) and the AXI/debug loader (P1).
// The grant is combinational. The response returns one cycle later to the port that owned the grant.
module instr_ram_arbiter
  import instr_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int ARB_MODE     = ARB_MODE_PRIO,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  instr_ram_arbiter_if.slave      p0,
  instr_ram_arbiter_if.slave      p1,
  output logic                    mem_en_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_p1_wins_tie;
  logic       w_rvalid0;
  logic       w_rvalid1;
  arb_owner_e w_winner;
  logic       r_rsp_valid;
  arb_owner_e r_rsp_owner;

  // The tie-break source is the only difference between the two modes.
  generate
    if (ARB_MODE == ARB_MODE_PRIO) begin : g_starve
      logic w_at_limit;

      instr_arb_wait_counter u_wait_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inc      (p1.req && !w_gnt1),
        .i_clr      (!p1.req || w_gnt1),
        .i_limit    (WAIT_CNT_W'(STARVE_LIMIT)),
        .o_at_limit (w_at_limit)
      );

      assign w_p1_wins_tie = w_at_limit;
    end else begin : g_rr
      arb_owner_e r_last_owner;

      // The reset value makes P0 win the first tie.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_last_owner <= OWNER_P1;
        end else if (w_gnt0 || w_gnt1) begin
          r_last_owner <= w_winner;
        end
      end

      assign w_p1_wins_tie = (r_last_owner == OWNER_P0);
    end
  endgenerate

  always_comb begin
    w_gnt1   = p1.req && (!p0.req || w_p1_wins_tie);
    w_gnt0   = p0.req && !w_gnt1;
    w_winner = w_gnt1 ? OWNER_P1 : OWNER_P0;
  end

  // An idle memory port drives all zeros, so no stale write strobes reach the RAM.
  always_comb begin
    mem_en_o    = w_gnt0 || w_gnt1;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (w_gnt0) begin
      mem_addr_o  = p0.addr;
      mem_we_o    = p0.we;
      mem_be_o    = p0.be;
      mem_wdata_o = p0.wdata;
    end else if (w_gnt1) begin
      mem_addr_o  = p1.addr;
      mem_we_o    = p1.we;
      mem_be_o    = p1.be;
      mem_wdata_o = p1.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_owner <= OWNER_P0;
    end else begin
      r_rsp_valid <= w_gnt0 || w_gnt1;
      r_rsp_owner <= w_winner;
    end
  end

  assign w_rvalid0 = r_rsp_valid && (r_rsp_owner == OWNER_P0);
  assign w_rvalid1 = r_rsp_valid && (r_rsp_owner == OWNER_P1);

  assign p0.gnt    = w_gnt0;
  assign p1.gnt    = w_gnt1;
  assign p0.rvalid = w_rvalid0;
  assign p1.rvalid = w_rvalid1;
  assign p0.rdata  = w_rvalid0 ? mem_rdata_i : '0;
  assign p1.rdata  = w_rvalid1 ? mem_rdata_i : '0;
endmodule
